// File: rtl/keypad_pkg.sv
// Shared types and constants for the 16-button keypad front end.
// Mode enum, note sentinel and a lowest-set-index helper.
package keypad_pkg;

    typedef enum logic [1:0] {
        MODE_SQUARE,
        MODE_SAW,
        MODE_TRI,
        MODE_SINE
    } mode_t;

    localparam logic [3:0] NOTE_NONE     = 4'hF;
    localparam int         MODE_KEY      = 15;
    localparam int         NUM_NOTE_KEYS = 15;

    function automatic logic [3:0] lowest_idx(
        input logic [NUM_NOTE_KEYS-1:0] v
    );
        logic [3:0] idx;
        idx = NOTE_NONE;
        for (int i = NUM_NOTE_KEYS - 1; i >= 0; i--) begin
            if (v[i]) idx = 4'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// One-bit synchroniser and debouncer for a raw push-button.
// Counters exist only when KEYPAD_DEBOUNCE_EN is defined.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic n_rst,
    input  logic pb_i,
    output logic deb_o
);

    logic sync1_q;
    logic sync2_q;
    logic deb_q;

`ifdef KEYPAD_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             deb_d;

    // Any return to the settled value restarts the count.
    always_comb begin
        deb_d = deb_q;
        cnt_d = '0;
        if (sync2_q != deb_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                deb_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            deb_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= pb_i;
            sync2_q <= sync1_q;
            deb_q   <= deb_d;
            cnt_q   <= cnt_d;
        end
    end
`else
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            deb_q   <= 1'b0;
        end else begin
            sync1_q <= pb_i;
            sync2_q <= sync1_q;
            deb_q   <= sync2_q;
        end
    end
`endif

    assign deb_o = deb_q;

endmodule

// File: rtl/key_mode_ctrl.sv
// Keypad front end: debounce, mode FSM on pb[15], last-pressed note arbiter.
// Debounce filtering is enabled by defining KEYPAD_DEBOUNCE_EN.
import keypad_pkg::*;

module key_mode_ctrl #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic [15:0] pb,
    output logic [1:0]  mode,
    output logic        mode_change,
    output logic [3:0]  note,
    output logic        note_valid,
    output logic        note_start
);

    logic [15:0] deb;
    logic [15:0] deb_q;
    logic [15:0] rise;
    logic [15:0] held;

    for (genvar g = 0; g < 16; g++) begin : g_deb
        key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .clk   (clk),
            .n_rst (n_rst),
            .pb_i  (pb[g]),
            .deb_o (deb[g])
        );
    end

    assign rise = deb & ~deb_q;
    // Bit 15 forced low so a NOTE_NONE index never reads the mode key.
    assign held = {1'b0, deb[NUM_NOTE_KEYS-1:0]};

    mode_t      mode_q, mode_d;
    logic       mode_change_q, mode_change_d;
    logic [3:0] note_q, note_d;
    logic       note_valid_q, note_valid_d;
    logic       note_start_q, note_start_d;

    always_comb begin
        mode_d        = mode_q;
        mode_change_d = 1'b0;
        if (rise[MODE_KEY]) begin
            mode_d        = mode_t'(mode_q + 2'd1);
            mode_change_d = 1'b1;
        end
    end

    always_comb begin
        note_d       = note_q;
        note_valid_d = note_valid_q;
        note_start_d = 1'b0;
        if (|rise[NUM_NOTE_KEYS-1:0]) begin
            note_d       = lowest_idx(rise[NUM_NOTE_KEYS-1:0]);
            note_valid_d = 1'b1;
            note_start_d = 1'b1;
        end else if (note_valid_q && !held[note_q]) begin
            note_d       = lowest_idx(deb[NUM_NOTE_KEYS-1:0]);
            note_valid_d = |deb[NUM_NOTE_KEYS-1:0];
            note_start_d = |deb[NUM_NOTE_KEYS-1:0];
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            deb_q         <= '0;
            mode_q        <= MODE_SQUARE;
            mode_change_q <= 1'b0;
            note_q        <= NOTE_NONE;
            note_valid_q  <= 1'b0;
            note_start_q  <= 1'b0;
        end else begin
            deb_q         <= deb;
            mode_q        <= mode_d;
            mode_change_q <= mode_change_d;
            note_q        <= note_d;
            note_valid_q  <= note_valid_d;
            note_start_q  <= note_start_d;
        end
    end

    assign mode        = mode_q;
    assign mode_change = mode_change_q;
    assign note        = note_q;
    assign note_valid  = note_valid_q;
    assign note_start  = note_start_q;

endmodule

// File: tb/tb_key_mode_ctrl.sv
// Directed table-driven bench for key_mode_ctrl, plus corner sequences.
// Latencies follow whether KEYPAD_DEBOUNCE_EN is defined.
module tb_key_mode_ctrl;

    localparam int D = 4;
`ifdef KEYPAD_DEBOUNCE_EN
    localparam int LAT = D + 2;
`else
    localparam int LAT = 3;
`endif
    // Ticks from applying pb until the resulting event is visible.
    localparam int EV = LAT + 1;

    logic        clk;
    logic        n_rst;
    logic [15:0] pb;
    logic [1:0]  mode;
    logic        mode_change;
    logic [3:0]  note;
    logic        note_valid;
    logic        note_start;

    int n_checks = 0;
    int n_fail   = 0;

    key_mode_ctrl #(
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .pb          (pb),
        .mode        (mode),
        .mode_change (mode_change),
        .note        (note),
        .note_valid  (note_valid),
        .note_start  (note_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [15:0] pb;
        int          wait_n;
        logic [1:0]  mode;
        logic        mc;
        logic [3:0]  note;
        logic        nv;
        logic        ns;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input string nm, input logic [15:0] p,
                                input int w, input logic [1:0] m,
                                input logic mc, input logic [3:0] n,
                                input logic nv, input logic ns);
        vec_t v;
        v.name = nm; v.pb = p; v.wait_n = w; v.mode = m;
        v.mc = mc; v.note = n; v.nv = nv; v.ns = ns;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [1:0] em,
                         input logic emc, input logic [3:0] en,
                         input logic env, input logic ens);
        logic [8:0] got;
        logic [8:0] exp;
        got = {mode, mode_change, note, note_valid, note_start};
        exp = {em, emc, en, env, ens};
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got mode=%0d mc=%b note=%h nv=%b ns=%b, expected mode=%0d mc=%b note=%h nv=%b ns=%b",
                     nm, mode, mode_change, note, note_valid, note_start,
                     em, emc, en, env, ens);
        end
    endtask

    task automatic apply_reset();
        pb    = 16'h0000;
        n_rst = 1'b0;
        tick();
        tick();
        n_rst = 1'b1;
        repeat (3) tick();
    endtask

    initial begin
        bit seen_start;
        logic [3:0] seen_note;

        vecs.push_back(mk("mode_pre",     16'h8000, EV-1, 2'd0, 0, 4'hF, 0, 0));
        vecs.push_back(mk("mode_step1",   16'h8000, 1,    2'd1, 1, 4'hF, 0, 0));
        vecs.push_back(mk("mode_pulse1",  16'h8000, 1,    2'd1, 0, 4'hF, 0, 0));
        vecs.push_back(mk("mode_hold",    16'h8000, 5,    2'd1, 0, 4'hF, 0, 0));
        vecs.push_back(mk("mode_rel1",    16'h0000, EV+1, 2'd1, 0, 4'hF, 0, 0));
        vecs.push_back(mk("mode_step2",   16'h8000, EV,   2'd2, 1, 4'hF, 0, 0));
        vecs.push_back(mk("mode_rel2",    16'h0000, EV+1, 2'd2, 0, 4'hF, 0, 0));
        vecs.push_back(mk("mode_step3",   16'h8000, EV,   2'd3, 1, 4'hF, 0, 0));
        vecs.push_back(mk("mode_rel3",    16'h0000, EV+1, 2'd3, 0, 4'hF, 0, 0));
        vecs.push_back(mk("mode_wrap",    16'h8000, EV,   2'd0, 1, 4'hF, 0, 0));
        vecs.push_back(mk("mode_rel4",    16'h0000, EV+1, 2'd0, 0, 4'hF, 0, 0));
        vecs.push_back(mk("note7",        16'h0080, EV,   2'd0, 0, 4'd7, 1, 1));
        vecs.push_back(mk("note7_hold",   16'h0080, 1,    2'd0, 0, 4'd7, 1, 0));
        vecs.push_back(mk("note2",        16'h0084, EV,   2'd0, 0, 4'd2, 1, 1));
        vecs.push_back(mk("note2_hold",   16'h0084, 1,    2'd0, 0, 4'd2, 1, 0));
        vecs.push_back(mk("back_to7",     16'h0080, EV,   2'd0, 0, 4'd7, 1, 1));
        vecs.push_back(mk("back7_hold",   16'h0080, 1,    2'd0, 0, 4'd7, 1, 0));
        vecs.push_back(mk("all_off",      16'h0000, EV,   2'd0, 0, 4'hF, 0, 0));
        vecs.push_back(mk("simul",        16'h8220, EV,   2'd1, 1, 4'd5, 1, 1));
        vecs.push_back(mk("simul_rel",    16'h0000, EV+1, 2'd1, 0, 4'hF, 0, 0));

        // Reset with every button held.
        n_rst = 1'b0;
        pb    = 16'hFFFF;
        repeat (3) tick();
        check("reset_vals", 2'd0, 0, 4'hF, 0, 0);
        n_rst = 1'b1;
        repeat (EV - 1) tick();
        check("rst_rel_pre", 2'd0, 0, 4'hF, 0, 0);
        tick();
        check("rst_rel_evt", 2'd1, 1, 4'd0, 1, 1);
        repeat (8) tick();
        check("rst_rel_hold", 2'd1, 0, 4'd0, 1, 0);

        apply_reset();
        foreach (vecs[i]) begin
            pb = vecs[i].pb;
            repeat (vecs[i].wait_n) tick();
            check(vecs[i].name, vecs[i].mode, vecs[i].mc, vecs[i].note,
                  vecs[i].nv, vecs[i].ns);
        end

        // Three-cycle glitch on pb[3].
        seen_start = 1'b0;
        seen_note  = 4'hF;
        pb = 16'h0008;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (note_start) begin seen_start = 1'b1; seen_note = note; end
        end
        pb = 16'h0000;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (note_start) begin seen_start = 1'b1; seen_note = note; end
        end
        n_checks++;
`ifdef KEYPAD_DEBOUNCE_EN
        if (seen_start !== 1'b0) begin
            n_fail++;
            $display("FAIL glitch: got start=%b note=%h, expected no start",
                     seen_start, seen_note);
        end
`else
        if (seen_start !== 1'b1 || seen_note !== 4'd3) begin
            n_fail++;
            $display("FAIL glitch: got start=%b note=%h, expected start=1 note=3",
                     seen_start, seen_note);
        end
`endif
        check("glitch_after", 2'd1, 0, 4'hF, 0, 0);

        // Asynchronous reset mid-note and mid-debounce.
        pb = 16'h1000;
        repeat (EV) tick();
        check("note12", 2'd1, 0, 4'd12, 1, 1);
        pb = 16'h9000;
        repeat (3) tick();
        n_rst = 1'b0;
        #1;
        check("async_rst", 2'd0, 0, 4'hF, 0, 0);
        tick();
        tick();
        n_rst = 1'b1;
        repeat (EV - 1) tick();
        check("rerun_pre", 2'd0, 0, 4'hF, 0, 0);
        tick();
        check("rerun_evt", 2'd1, 1, 4'd12, 1, 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
